commit_trace_buffer: RTL and testbench

Synthesizable commit-trace capture unit for the RV32 core. It takes up to `NRET` retired instructions per cycle from the core's retire channels and classifies each one as a register write, load, store, or bare commit. Classified records are tagged with a global sequence number and buffered in a multi-push, single-pop FIFO. Records drain through a valid/ready stream to an on-chip checker or debug port, replacing simulation-only `$display` commit logging with a hardware path that works on FPGA and in co-simulation.

---
 rtl/riscv_pkg.sv | 103 ++++++++++
 rtl/commit_trace_buffer_fifo.sv | 57 +++++
 rtl/commit_trace_buffer.sv | 122 ++++++++++++
 tb/tb_commit_trace_buffer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 core types plus the commit-trace record format and the
// per-channel classification used by commit_trace_buffer.
package riscv_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned TRACE_SEQW = 32;

   typedef enum logic [3:0] {
      OP_NOP,
      OP_ALU,
      OP_LUI,
      OP_AUIPC,
      OP_JAL,
      OP_JALR,
      OP_BRANCH,
      OP_LB,
      OP_LH,
      OP_LW,
      OP_LBU,
      OP_LHU,
      OP_SB,
      OP_SH,
      OP_SW,
      OP_CSR
   } operation_e;

   typedef enum logic [1:0] {
      TR_NONE,
      TR_REG,
      TR_LOAD,
      TR_STORE
   } trace_kind_e;

   typedef enum logic [1:0] {
      SZ_BYTE,
      SZ_HALF,
      SZ_WORD
   } trace_size_e;

   typedef struct packed {
      logic [TRACE_SEQW-1:0] seq;
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       instr;
      trace_kind_e           kind;
      trace_size_e           size;
      logic [4:0]            rd;
      logic [XLEN-1:0]       data;
      logic [XLEN-1:0]       addr;
   } trace_rec_t;

   // Builds the record body for one retire channel; seq is left at zero and
   // filled in by the caller once the keep mask is known.
   function automatic trace_rec_t trace_classify(
      input logic [XLEN-1:0] pc,
      input logic [XLEN-1:0] instr,
      input logic [4:0]      rd,
      input logic [XLEN-1:0] rd_data,
      input logic            rf_we,
      input logic            mem_re,
      input logic            mem_we,
      input logic [XLEN-1:0] mem_addr,
      input logic [XLEN-1:0] mem_wdata,
      input operation_e      op
   );
      trace_rec_t r;
      r       = '0;
      r.pc    = pc;
      r.instr = instr;
      r.kind  = TR_NONE;
      r.size  = SZ_WORD;
      if (mem_we) begin
         r.kind = TR_STORE;
         r.addr = mem_addr;
         case (op)
            OP_SB: begin
               r.size = SZ_BYTE;
               r.data = XLEN'(mem_wdata[7:0]);
            end
            OP_SH: begin
               r.size = SZ_HALF;
               r.data = XLEN'(mem_wdata[15:0]);
            end
            default: begin
               r.size = SZ_WORD;
               r.data = mem_wdata;
            end
         endcase
      end else if (mem_re) begin
         if (rd != 5'd0) begin
            r.kind = TR_LOAD;
            r.rd   = rd;
            r.data = rd_data;
            r.addr = mem_addr;
         end
      end else if (rf_we && (rd != 5'd0)) begin
         r.kind = TR_REG;
         r.rd   = rd;
         r.data = rd_data;
      end
      return r;
   endfunction

endpackage

// File: rtl/commit_trace_buffer_fifo.sv
// Multi-push, single-pop FIFO: accepts up to NRET already-compacted entries
// per cycle and presents the oldest entry at the head.
module trace_mpush_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned NRET  = 2,
   parameter type         T     = logic
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [$clog2(NRET+1)-1:0]  push_cnt,
   input  T                           push_data [NRET],
   input  logic                       pop,
   output logic                       valid,
   output T                           head,
   output logic                       ready
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   T                mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;

   assign count_next = count + CW'(push_cnt) - CW'(pop);
   assign valid      = (count != '0);
   assign head       = mem[rd_ptr];

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NRET; i++) begin
         if (i < 32'(push_cnt)) begin
            mem[wr_ptr + AW'(i)] <= push_data[i];
         end
      end
   end

   // ready tracks free space for the next cycle; an empty FIFO always has room,
   // so it comes out of reset high.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ready  <= 1'b1;
      end else begin
         wr_ptr <= wr_ptr + AW'(push_cnt);
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_next;
         ready <= (count_next <= CW'(DEPTH - NRET));
      end
   end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-trace capture: classifies up to NRET retires per cycle, tags kept
// records with a global sequence number and queues them for a valid/ready drain.
module commit_trace_buffer
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN  = riscv_pkg::XLEN,
   parameter int unsigned NRET  = 2,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned SEQW  = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           trace_en_i,
   input  logic                           mem_only_i,
   input  logic [NRET-1:0]                ret_valid_i,
   input  logic [NRET-1:0][XLEN-1:0]      ret_pc_i,
   input  logic [NRET-1:0][XLEN-1:0]      ret_instr_i,
   input  logic [NRET-1:0][4:0]           ret_rd_i,
   input  logic [NRET-1:0][XLEN-1:0]      ret_rd_data_i,
   input  logic [NRET-1:0]                ret_rf_we_i,
   input  logic [NRET-1:0]                ret_mem_re_i,
   input  logic [NRET-1:0]                ret_mem_we_i,
   input  logic [NRET-1:0][XLEN-1:0]      ret_mem_addr_i,
   input  logic [NRET-1:0][XLEN-1:0]      ret_mem_wdata_i,
   input  operation_e [NRET-1:0]          ret_op_i,
   output logic                           ret_ready_o,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output trace_rec_t                     out_rec_o,
   output logic [15:0]                    drop_count_o,
   output logic                           overflow_o
);

   localparam int unsigned PW = $clog2(NRET + 1);

   logic [SEQW-1:0]  seq;
   logic [15:0]      drop_count;
   logic             overflow;
   logic [16:0]      drop_sum;

   trace_rec_t       recs      [NRET];
   trace_rec_t       push_data [NRET];
   logic [PW-1:0]    offs      [NRET];
   logic [NRET-1:0]  keep;
   logic [PW-1:0]    nkeep;
   logic [PW-1:0]    push_cnt;
   logic [PW-1:0]    drops;

   logic             ready_q;
   logic             ready;
   logic             pop;

   // Classification and exclusive prefix sum over the keep mask.
   always_comb begin
      nkeep = '0;
      for (int unsigned k = 0; k < NRET; k++) begin
         recs[k] = trace_classify(ret_pc_i[k], ret_instr_i[k], ret_rd_i[k],
                                  ret_rd_data_i[k], ret_rf_we_i[k],
                                  ret_mem_re_i[k], ret_mem_we_i[k],
                                  ret_mem_addr_i[k], ret_mem_wdata_i[k],
                                  ret_op_i[k]);
         keep[k] = ret_valid_i[k] && trace_en_i && (ret_pc_i[k] != '0) &&
                   (!mem_only_i || (recs[k].kind inside {TR_LOAD, TR_STORE}));
         offs[k] = nkeep;
         nkeep   = nkeep + PW'(keep[k]);
      end
   end

   // Slot j receives the kept channel whose prefix offset equals j.
   always_comb begin
      for (int unsigned j = 0; j < NRET; j++) begin
         push_data[j] = '0;
         for (int unsigned k = 0; k < NRET; k++) begin
            if (keep[k] && (offs[k] == PW'(j))) begin
               push_data[j]     = recs[k];
               push_data[j].seq = TRACE_SEQW'(seq + SEQW'(offs[k]));
            end
         end
      end
      push_cnt = ready ? nkeep : '0;
      drops    = ready ? '0 : nkeep;
      drop_sum = {1'b0, drop_count} + 17'(drops);
   end

   // Dropped records still consume sequence numbers so the consumer sees a gap.
   always_ff @(posedge clk) begin
      if (rst) begin
         seq        <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
      end else begin
         seq <= seq + SEQW'(nkeep);
         if (drops != '0) begin
            overflow   <= 1'b1;
            drop_count <= drop_sum[16] ? '1 : drop_sum[15:0];
         end
      end
   end

   trace_mpush_fifo #(
      .DEPTH (DEPTH),
      .NRET  (NRET),
      .T     (trace_rec_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_cnt  (push_cnt),
      .push_data (push_data),
      .pop       (pop),
      .valid     (out_valid_o),
      .head      (out_rec_o),
      .ready     (ready_q)
   );

   // Masked during reset so the retire side never sees space it cannot use.
   assign ready        = ready_q && !rst;
   assign ret_ready_o  = ready;
   assign pop          = out_valid_o && out_ready_i;
   assign drop_count_o = drop_count;
   assign overflow_o   = overflow;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer with a queue-based reference model
// checked every cycle, plus literal expectations on key records.
module tb_commit_trace_buffer;
   import riscv_pkg::*;

   localparam int unsigned NRET  = 2;
   localparam int unsigned DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic trace_en, mem_only, out_ready;
   logic [NRET-1:0]             ret_valid, rf_we, mem_re, mem_we;
   logic [NRET-1:0][31:0]       pc, instr, rd_data, maddr, wdata;
   logic [NRET-1:0][4:0]        rd;
   operation_e [NRET-1:0]       op;

   logic        ready, out_valid, overflow;
   trace_rec_t  out_rec;
   logic [15:0] drop_count;

   commit_trace_buffer #(
      .NRET  (NRET),
      .DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .trace_en_i      (trace_en),
      .mem_only_i      (mem_only),
      .ret_valid_i     (ret_valid),
      .ret_pc_i        (pc),
      .ret_instr_i     (instr),
      .ret_rd_i        (rd),
      .ret_rd_data_i   (rd_data),
      .ret_rf_we_i     (rf_we),
      .ret_mem_re_i    (mem_re),
      .ret_mem_we_i    (mem_we),
      .ret_mem_addr_i  (maddr),
      .ret_mem_wdata_i (wdata),
      .ret_op_i        (op),
      .ret_ready_o     (ready),
      .out_valid_o     (out_valid),
      .out_ready_i     (out_ready),
      .out_rec_o       (out_rec),
      .drop_count_o    (drop_count),
      .overflow_o      (overflow)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   trace_rec_t q[$];
   logic [31:0] mseq = '0;
   int          mdrop = 0;
   bit          movf = 1'b0;
   bit          mrdy = 1'b0;

   task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic trace_rec_t mrec(input logic c);
      trace_rec_t r;
      r       = '0;
      r.pc    = pc[c];
      r.instr = instr[c];
      r.size  = SZ_WORD;
      if (mem_we[c]) begin
         r.kind = TR_STORE;
         r.addr = maddr[c];
         if (op[c] == OP_SB) begin
            r.size = SZ_BYTE;
            r.data = wdata[c] & 32'h0000_00FF;
         end else if (op[c] == OP_SH) begin
            r.size = SZ_HALF;
            r.data = wdata[c] & 32'h0000_FFFF;
         end else begin
            r.data = wdata[c];
         end
      end else if (mem_re[c]) begin
         if (rd[c] != 5'd0) begin
            r.kind = TR_LOAD;
            r.rd   = rd[c];
            r.data = rd_data[c];
            r.addr = maddr[c];
         end
      end else if (rf_we[c] && rd[c] != 5'd0) begin
         r.kind = TR_REG;
         r.rd   = rd[c];
         r.data = rd_data[c];
      end
      return r;
   endfunction

   function automatic bit mkeep(input logic c);
      bit memop;
      memop = mem_we[c] || (mem_re[c] && rd[c] != 5'd0);
      return ret_valid[c] && trace_en && (pc[c] != 32'd0) && (!mem_only || memop);
   endfunction

   // Reference model: one queue, one sequence counter, drops when no room was advertised.
   always @(posedge clk) begin
      bit accept;
      trace_rec_t r;
      if (rst) begin
         q.delete();
         mseq  = '0;
         mdrop = 0;
         movf  = 1'b0;
         mrdy  = 1'b1;
      end else begin
         accept = mrdy;
         if (out_ready && q.size() != 0) void'(q.pop_front());
         for (int k = 0; k < NRET; k++) begin
            if (mkeep(1'(k))) begin
               r     = mrec(1'(k));
               r.seq = mseq;
               mseq  = mseq + 1;
               if (accept) q.push_back(r);
               else begin
                  if (mdrop < 65535) mdrop++;
                  movf = 1'b1;
               end
            end
         end
         mrdy = (DEPTH - q.size()) >= NRET;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", out_valid, q.size() != 0);
         if (q.size() != 0) check("out_rec", out_rec, q[0]);
         check("ret_ready", ready, mrdy && !rst);
         check("drop_count", drop_count, mdrop[15:0]);
         check("overflow", overflow, movf);
      end
   end

   task automatic clear_all();
      ret_valid = '0; rf_we = '0; mem_re = '0; mem_we = '0;
      pc = '0; instr = '0; rd_data = '0; maddr = '0; wdata = '0; rd = '0;
      op[0] = OP_NOP; op[1] = OP_NOP;
   endtask

   task automatic drive(input logic c, input logic [31:0] p, input logic [31:0] ins,
                        input logic [4:0] r, input logic [31:0] d,
                        input logic f_rf, input logic f_re, input logic f_we,
                        input logic [31:0] a, input logic [31:0] wd, input operation_e o);
      ret_valid[c] = 1'b1; pc[c] = p; instr[c] = ins; rd[c] = r; rd_data[c] = d;
      rf_we[c] = f_rf; mem_re[c] = f_re; mem_we[c] = f_we;
      maddr[c] = a; wdata[c] = wd; op[c] = o;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic dual_push(input logic [31:0] base);
      drive(1'b0, base, 32'h00b52023, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, base + 32'h1000, base ^ 32'hCAFE_F00D, OP_SW);
      drive(1'b1, base + 4, 32'h00052583, 5'd11, base + 32'h55, 1'b1, 1'b1, 1'b0, base + 32'h2000, 32'd0, OP_LW);
      step();
      clear_all();
   endtask

   initial begin
      clear_all();
      trace_en = 1'b1; mem_only = 1'b0; out_ready = 1'b0;
      step();
      chk_en = 1'b1;
      check("rst_valid", out_valid, 1'b0);
      check("rst_ready", ready, 1'b0);
      check("rst_drop", drop_count, 16'd0);
      check("rst_ovf", overflow, 1'b0);
      rst = 1'b0;
      #1;
      check("ready_first_cycle", ready, 1'b1);
      step();

      // REG record
      out_ready = 1'b1;
      drive(1'b0, 32'h80000004, 32'h00500093, 5'd1, 32'h5, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, OP_ALU);
      step(); clear_all();
      check("reg_valid", out_valid, 1'b1);
      check("reg_kind", out_rec.kind, TR_REG);
      check("reg_rd", out_rec.rd, 5'd1);
      check("reg_data", out_rec.data, 32'h00000005);
      check("reg_seq", out_rec.seq, 32'd0);

      // SB size masking
      drive(1'b0, 32'h80000008, 32'h00b50023, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h80001000, 32'h12345678, OP_SB);
      step(); clear_all();
      check("sb_kind", out_rec.kind, TR_STORE);
      check("sb_size", out_rec.size, SZ_BYTE);
      check("sb_data", out_rec.data, 32'h00000078);
      check("sb_addr", out_rec.addr, 32'h80001000);
      check("sb_seq", out_rec.seq, 32'd1);

      // dual retire, channel order
      drive(1'b0, 32'h100, 32'h00a00113, 5'd2, 32'hAA, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, OP_ALU);
      drive(1'b1, 32'h104, 32'h0001a183, 5'd3, 32'hBB, 1'b1, 1'b1, 1'b0, 32'h2000, 32'd0, OP_LW);
      step(); clear_all();
      check("dual0_pc", out_rec.pc, 32'h100);
      check("dual0_seq", out_rec.seq, 32'd2);
      step();
      check("dual1_pc", out_rec.pc, 32'h104);
      check("dual1_seq", out_rec.seq, 32'd3);
      check("dual1_kind", out_rec.kind, TR_LOAD);
      check("dual1_addr", out_rec.addr, 32'h2000);

      // filtering: pc=0, trace disabled, mem_only with REG and rd=0 load
      drive(1'b0, 32'h0, 32'h00400213, 5'd4, 32'h44, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, OP_ALU);
      step(); clear_all();
      trace_en = 1'b0;
      drive(1'b1, 32'h200, 32'h00500293, 5'd5, 32'h55, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, OP_ALU);
      step(); clear_all();
      trace_en = 1'b1; mem_only = 1'b1;
      drive(1'b0, 32'h204, 32'h00600313, 5'd6, 32'h66, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, OP_ALU);
      drive(1'b1, 32'h208, 32'h00052003, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'd0, OP_LW);
      step(); clear_all();
      mem_only = 1'b0;
      check("filter_empty", out_valid, 1'b0);
      out_ready = 1'b0;
      drive(1'b0, 32'h20C, 32'h00700393, 5'd7, 32'h77, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, OP_ALU);
      step(); clear_all();
      check("filter_seq", out_rec.seq, 32'd4);

      // overflow: one queued + three full pushes leaves one free slot
      dual_push(32'h400); dual_push(32'h410); dual_push(32'h420);
      check("full_ready", ready, 1'b0);
      dual_push(32'h430);
      check("ovf_drop", drop_count, 16'd2);
      check("ovf_flag", overflow, 1'b1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("ovf_ready_back", ready, 1'b1);
      drive(1'b0, 32'h300, 32'h00800413, 5'd8, 32'h88, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, OP_ALU);
      step(); clear_all();
      check("refull_ready", ready, 1'b0);
      out_ready = 1'b1;
      repeat (6) step();
      check("gap_seq", out_rec.seq, 32'd13);
      check("gap_pc", out_rec.pc, 32'h300);

      // reset with five records queued
      out_ready = 1'b0;
      dual_push(32'h500); dual_push(32'h510);
      check("five_ready", ready, 1'b1);
      rst = 1'b1;
      step();
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_ovf", overflow, 1'b0);
      check("mid_rst_drop", drop_count, 16'd0);
      rst = 1'b0;
      drive(1'b0, 32'h600, 32'h00900493, 5'd9, 32'h99, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, OP_ALU);
      step(); clear_all();
      check("post_rst_seq", out_rec.seq, 32'd0);
      check("post_rst_valid", out_valid, 1'b1);

      // mixed classifications with stalled and flowing drain
      drive(1'b0, 32'h700, 32'h00b51023, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h4002, 32'hDEAD_BEEF, OP_SH);
      drive(1'b1, 32'h704, 32'h00050003, 5'd0, 32'h1, 1'b1, 1'b1, 1'b0, 32'h4004, 32'd0, OP_LB);
      step(); clear_all();
      out_ready = 1'b1;
      drive(1'b0, 32'h708, 32'h00000013, 5'd0, 32'h5, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, OP_ALU);
      drive(1'b1, 32'h70C, 32'h0000006f, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, OP_JAL);
      step(); clear_all();
      out_ready = 1'b0;
      mem_only = 1'b1;
      drive(1'b0, 32'h710, 32'h00c52023, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h5000, 32'h0BAD_F00D, OP_SW);
      drive(1'b1, 32'h714, 32'h00052683, 5'd13, 32'h1313, 1'b1, 1'b1, 1'b0, 32'h5004, 32'd0, OP_LW);
      step(); clear_all();
      mem_only = 1'b0;
      drive(1'b1, 32'h718, 32'h00e00713, 5'd14, 32'h1414, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, OP_ALU);
      step(); clear_all();
      out_ready = 1'b1;
      repeat (12) step();
      check("final_empty", out_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
